// File: rtl/hpdcache_arb_pkg.sv
// Shared definitions for the HPDcache shared-port arbiters.
//   hpdcache_arb_state_e : arbitration state (free to arbitrate / grant locked)
//   hpdcache_arb_idw()   : width of a requester index, never less than one bit
package hpdcache_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCK} hpdcache_arb_state_e;

  function automatic int unsigned hpdcache_arb_idw(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hpdcache_burst_rrmux_if.sv
// Bundle of the N-to-1 burst channel: N upstream beat channels plus one
// downstream channel and the lock status.
//   master : requesters and downstream sink (drives valid/last/data, out_ready)
//   slave  : the multiplexer (drives ready, out_* and busy)
interface hpdcache_burst_rrmux_if
  import hpdcache_arb_pkg::*;
#(
  parameter int unsigned N   = 2,
  parameter int unsigned W   = 64,
  parameter int unsigned IDW = hpdcache_arb_idw(N)
);
  logic [N-1:0]   req_valid_i;
  logic [N-1:0]   req_ready_o;
  logic [N-1:0]   req_last_i;
  logic [N*W-1:0] req_data_i;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [W-1:0]   out_data_o;
  logic           out_last_o;
  logic [IDW-1:0] out_id_o;
  logic           busy_o;

  modport master (
    output req_valid_i, req_last_i, req_data_i, out_ready_i,
    input  req_ready_o, out_valid_o, out_data_o, out_last_o, out_id_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_last_i, req_data_i, out_ready_i,
    output req_ready_o, out_valid_o, out_data_o, out_last_o, out_id_o, busy_o
  );
endinterface

// File: rtl/hpdcache_prio_1hot_encoder.sv
// Fixed-priority one-hot encoder: keeps only the lowest set bit of val_i.
//   val_i : request vector
//   val_o : one-hot (or zero) grant, bit 0 has the highest priority
module hpdcache_prio_1hot_encoder #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] val_i,
  output logic [N-1:0] val_o
);
  // x & -x isolates the least significant set bit.
  assign val_o = val_i & (~val_i + N'(1));
endmodule

// File: rtl/hpdcache_rr_pick.sv
// Combinational rotating-priority picker. Scans ptr+1, ptr+2, ... modulo N
// and grants the first active request.
//   req    : request vector
//   ptr    : index of the most recently served requester
//   gnt    : one-hot grant (zero when nothing requests)
//   gnt_id : index of the granted requester (zero when nothing requests)
//   any    : at least one request is active
module hpdcache_rr_pick
  import hpdcache_arb_pkg::*;
#(
  parameter int unsigned N   = 2,
  parameter int unsigned IDW = hpdcache_arb_idw(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);
  logic [N-1:0] mask;
  logic [N-1:0] req_masked;
  logic [N-1:0] gnt_masked;
  logic [N-1:0] gnt_unmasked;

  // Requesters strictly above ptr come first; if none of them is active the
  // unmasked pick wraps around to the lowest index.
  always_comb begin
    mask = '0;
    for (int unsigned k = 0; k < N; k++) begin
      mask[k] = (IDW'(k) > ptr);
    end
  end

  assign req_masked = req & mask;

  hpdcache_prio_1hot_encoder #(.N(N)) u_enc_masked (
    .val_i (req_masked),
    .val_o (gnt_masked)
  );

  hpdcache_prio_1hot_encoder #(.N(N)) u_enc_unmasked (
    .val_i (req),
    .val_o (gnt_unmasked)
  );

  assign gnt = (|req_masked) ? gnt_masked : gnt_unmasked;
  assign any = |req;

  always_comb begin
    gnt_id = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (gnt[k]) gnt_id = gnt_id | IDW'(k);
    end
  end
endmodule

// File: rtl/hpdcache_burst_rrmux.sv
// N-to-1 packet-granular round-robin multiplexer for multi-beat channels.
// Forwarding is combinational; only the arbitration state is registered.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : slave view of hpdcache_burst_rrmux_if (N request channels
//                  in, one downstream channel out, busy = grant locked)
//
// state    | meaning
// ---------+------------------------------------------------------------
// ARB_IDLE | free: winner chosen by rotating priority after ptr
// ARB_LOCK | grant held on lock_id until its last beat is accepted
module hpdcache_burst_rrmux
  import hpdcache_arb_pkg::*;
#(
  parameter int unsigned N         = 2,
  parameter int unsigned W         = 64,
  parameter int unsigned MAX_BEATS = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  hpdcache_burst_rrmux_if.slave bus
);
  localparam int unsigned IDW = hpdcache_arb_idw(N);
  localparam int unsigned BCW = $clog2(MAX_BEATS + 1);

  hpdcache_arb_state_e state_q, state_d;
  logic [IDW-1:0]      lock_id_q, lock_id_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [BCW-1:0]      beat_cnt_q, beat_cnt_d;

  logic [N-1:0]   pick_gnt;
  logic [IDW-1:0] pick_id;
  logic           pick_any;
  logic [IDW-1:0] winner_id;
  logic           win_valid;
  logic [W-1:0]   win_data;
  logic           win_last;
  logic           acc;
  logic [N-1:0]   ready;

  hpdcache_rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req    (bus.req_valid_i),
    .ptr    (ptr_q),
    .gnt    (pick_gnt),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  assign winner_id = (state_q == ARB_LOCK) ? lock_id_q : pick_id;

  // Reset gates the valid so outputs drop to zero the moment reset rises,
  // not at the next edge.
  always_comb begin
    win_valid = 1'b0;
    win_data  = '0;
    win_last  = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (IDW'(k) == winner_id) begin
        win_valid = bus.req_valid_i[k] & ~rst_i;
        win_data  = bus.req_data_i[k*W +: W];
        win_last  = bus.req_last_i[k];
      end
    end
  end

  assign acc = win_valid & bus.out_ready_i;

  always_comb begin
    ready = '0;
    if (state_q == ARB_LOCK) begin
      for (int unsigned k = 0; k < N; k++) begin
        ready[k] = (IDW'(k) == lock_id_q) & acc;
      end
    end else begin
      ready = pick_gnt & {N{acc}};
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.out_valid_o = win_valid;
  assign bus.out_data_o  = win_valid ? win_data : '0;
  assign bus.out_last_o  = win_valid & win_last;
  assign bus.out_id_o    = win_valid ? winner_id : '0;
  assign bus.busy_o      = (state_q == ARB_LOCK);

  always_comb begin
    state_d    = state_q;
    lock_id_d  = lock_id_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (state_q == ARB_IDLE) begin
      if (pick_any) begin
        if (acc && win_last) begin
          ptr_d      = winner_id;
          beat_cnt_d = '0;
        end else begin
          // A presented-but-unaccepted beat also locks: it must not be
          // re-arbitrated away before it is taken.
          state_d    = ARB_LOCK;
          lock_id_d  = winner_id;
          beat_cnt_d = acc ? BCW'(1) : '0;
        end
      end
    end else begin
      if (acc) begin
        if (win_last) begin
          state_d    = ARB_IDLE;
          ptr_d      = lock_id_q;
          beat_cnt_d = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + BCW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ARB_IDLE;
      lock_id_q  <= '0;
      ptr_q      <= IDW'(N - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_id_q  <= lock_id_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifndef SYNTHESIS
  a_ready_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(bus.req_ready_o));

  a_beat_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    (acc && !win_last) |-> (beat_cnt_q < BCW'(MAX_BEATS - 1)));

  a_hold_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (win_valid && !bus.out_ready_i) |=>
      (win_valid && $stable(win_data) && $stable(winner_id)));
`endif
endmodule

// File: tb/tb_hpdcache_burst_rrmux.sv
module tb_hpdcache_burst_rrmux;
  import hpdcache_arb_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned MB = 8;
  localparam int NI   = 3;
  localparam int NMAX = 4;

  typedef struct packed {
    logic         vld;
    logic [1:0]   id;
    logic [W-1:0] data;
    logic         lst;
    logic [3:0]   rdy;
    logic         busy;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  hpdcache_burst_rrmux_if #(.N(4), .W(W)) bus4 ();
  hpdcache_burst_rrmux_if #(.N(1), .W(W)) bus1 ();
  hpdcache_burst_rrmux_if #(.N(3), .W(W)) bus3 ();

  hpdcache_burst_rrmux #(.N(4), .W(W), .MAX_BEATS(MB)) u_dut4 (.clk_i(clk_i), .rst_i(rst_i), .bus(bus4));
  hpdcache_burst_rrmux #(.N(1), .W(W), .MAX_BEATS(MB)) u_dut1 (.clk_i(clk_i), .rst_i(rst_i), .bus(bus1));
  hpdcache_burst_rrmux #(.N(3), .W(W), .MAX_BEATS(MB)) u_dut3 (.clk_i(clk_i), .rst_i(rst_i), .bus(bus3));

  int n_of[NI] = '{4, 1, 3};

  // stimulus state per instance / requester
  logic         vld[NI][NMAX];
  logic         lst[NI][NMAX];
  logic [W-1:0] dat[NI][NMAX];
  logic         ordy[NI];
  int           rem[NI][NMAX];
  bit           refill[NI][NMAX];
  int           refill_len[NI][NMAX];
  bit           rnd_mode = 1'b0;

  // reference model: rotating priority after the last served requester,
  // grant held from first presentation until the packet's last beat is taken
  bit m_lck[NI];
  int m_lid[NI];
  int m_ptr[NI];
  int m_acc[NI];

  exp_t exp_q[NI][$];
  int   acc_log[NI][$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic void chk(string nm, int i, logic [W-1:0] act, logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s inst=%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
    end
  endfunction

  function automatic void clear_all();
    for (int i = 0; i < NI; i++)
      for (int k = 0; k < NMAX; k++) begin
        vld[i][k] = 1'b0; lst[i][k] = 1'b0; dat[i][k] = '0;
        rem[i][k] = 0; refill[i][k] = 1'b0; refill_len[i][k] = 1;
      end
  endfunction

  function automatic void clear_logs();
    for (int i = 0; i < NI; i++) acc_log[i].delete();
  endfunction

  function automatic void start_pkt(int i, int k, int len);
    rem[i][k] = len;
    vld[i][k] = 1'b1;
    lst[i][k] = (len == 1);
    dat[i][k] = W'($urandom);
  endfunction

  function automatic int pending();
    int p = 0;
    for (int i = 0; i < NI; i++)
      for (int k = 0; k < NMAX; k++)
        if (rem[i][k] > 0) p++;
    return p;
  endfunction

  function automatic int winner(int i);
    if (m_lck[i]) return m_lid[i];
    for (int s = 1; s <= n_of[i]; s++) begin
      int k = (m_ptr[i] + s) % n_of[i];
      if (vld[i][k]) return k;
    end
    return 0;
  endfunction

  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      bus4.req_valid_i[k] = vld[0][k];
      bus4.req_last_i[k]  = lst[0][k];
      bus4.req_data_i[k*W +: W] = dat[0][k];
    end
    bus4.out_ready_i = ordy[0];
    bus1.req_valid_i[0] = vld[1][0];
    bus1.req_last_i[0]  = lst[1][0];
    bus1.req_data_i     = dat[1][0];
    bus1.out_ready_i    = ordy[1];
    for (int k = 0; k < 3; k++) begin
      bus3.req_valid_i[k] = vld[2][k];
      bus3.req_last_i[k]  = lst[2][k];
      bus3.req_data_i[k*W +: W] = dat[2][k];
    end
    bus3.out_ready_i = ordy[2];
  endtask

  task automatic model_cycle();
    for (int i = 0; i < NI; i++) begin
      exp_t e;
      int   w;
      bit   a;
      e = '0;
      a = 1'b0;
      m_acc[i] = -1;
      if (rst_i) begin
        m_lck[i] = 1'b0; m_lid[i] = 0; m_ptr[i] = n_of[i] - 1;
      end else begin
        w = winner(i);
        e.busy = m_lck[i];
        if (vld[i][w]) begin
          e.vld  = 1'b1;
          e.id   = 2'(w);
          e.data = dat[i][w];
          e.lst  = lst[i][w];
          if (ordy[i]) begin
            e.rdy = 4'(1) << w;
            a = 1'b1;
          end
        end
        if (a) begin
          m_acc[i] = w;
          if (lst[i][w]) begin m_lck[i] = 1'b0; m_ptr[i] = w; end
          else begin m_lck[i] = 1'b1; m_lid[i] = w; end
        end else if (e.vld) begin
          m_lck[i] = 1'b1; m_lid[i] = w;
        end
      end
      exp_q[i].push_back(e);
    end
  endtask

  function automatic void advance();
    for (int i = 0; i < NI; i++) begin
      int k;
      k = m_acc[i];
      if (k >= 0) begin
        if (rem[i][k] > 1) begin
          rem[i][k]--;
          dat[i][k] = W'($urandom);
          lst[i][k] = (rem[i][k] == 1);
          if (rnd_mode && $urandom_range(3) == 0) vld[i][k] = 1'b0;
        end else begin
          rem[i][k] = 0; vld[i][k] = 1'b0; lst[i][k] = 1'b0;
          if (refill[i][k]) start_pkt(i, k, refill_len[i][k]);
        end
      end
    end
  endfunction

  function automatic void random_update();
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < n_of[i]; k++) begin
        if (!vld[i][k]) begin
          if (rem[i][k] == 0) begin
            if ($urandom_range(2) == 0) start_pkt(i, k, int'($urandom_range(MB, 1)));
          end else if ($urandom_range(3) != 0) begin
            vld[i][k] = 1'b1;
          end
        end
      end
      ordy[i] = ($urandom_range(3) != 0);
    end
  endfunction

  task automatic step();
    drive();
    model_cycle();
    @(posedge clk_i);
    #1;
    advance();
    if (rnd_mode) random_update();
  endtask

  task automatic drain();
    int c = 0;
    while (pending() > 0 && c < 300) begin
      for (int i = 0; i < NI; i++) begin
        ordy[i] = 1'b1;
        for (int k = 0; k < NMAX; k++)
          if (rem[i][k] > 0) vld[i][k] = 1'b1;
      end
      step();
      c++;
    end
    chk("drain_timeout", 0, W'(pending()), W'(0));
  endtask

  task automatic check_log(input string nm, input int i, input int n,
                           input int e0, input int e1, input int e2, input int e3);
    int ev[4];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    chk({nm, "_count"}, i, W'(acc_log[i].size()), W'(n));
    for (int j = 0; j < n && j < acc_log[i].size(); j++)
      chk(nm, i, W'(acc_log[i][j]), W'(ev[j]));
  endtask

  function automatic exp_t sample(int i);
    exp_t s;
    s = '0;
    case (i)
      0: begin
        s.vld = bus4.out_valid_o; s.id = 2'(bus4.out_id_o); s.data = bus4.out_data_o;
        s.lst = bus4.out_last_o; s.rdy = 4'(bus4.req_ready_o); s.busy = bus4.busy_o;
      end
      1: begin
        s.vld = bus1.out_valid_o; s.id = 2'(bus1.out_id_o); s.data = bus1.out_data_o;
        s.lst = bus1.out_last_o; s.rdy = 4'(bus1.req_ready_o); s.busy = bus1.busy_o;
      end
      default: begin
        s.vld = bus3.out_valid_o; s.id = 2'(bus3.out_id_o); s.data = bus3.out_data_o;
        s.lst = bus3.out_last_o; s.rdy = 4'(bus3.req_ready_o); s.busy = bus3.busy_o;
      end
    endcase
    return s;
  endfunction

  // monitor: one expected record per instance per cycle, compared mid-cycle
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk_i);
      for (int i = 0; i < NI; i++) begin
        if (exp_q[i].size() > 0) begin
          e = exp_q[i].pop_front();
          a = sample(i);
          chk("out_valid", i, W'(a.vld),  W'(e.vld));
          chk("out_id",    i, W'(a.id),   W'(e.id));
          chk("out_data",  i, a.data,     e.data);
          chk("out_last",  i, W'(a.lst),  W'(e.lst));
          chk("req_ready", i, W'(a.rdy),  W'(e.rdy));
          chk("busy",      i, W'(a.busy), W'(e.busy));
          if (a.vld && ordy[i]) acc_log[i].push_back(int'(a.id));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    clear_all();
    for (int i = 0; i < NI; i++) ordy[i] = 1'b0;
    drive();
    @(posedge clk_i);
    #1;
    step();
    rst_i = 1'b0;
    repeat (2) step();

    // fairness: four continuous single-beat requesters
    ordy[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      refill[0][k] = 1'b1; refill_len[0][k] = 1; start_pkt(0, k, 1);
    end
    clear_logs();
    repeat (12) step();
    for (int k = 0; k < 4; k++) refill[0][k] = 1'b0;
    drain();
    chk("fair_count", 0, W'(acc_log[0].size()), W'(16));
    for (int j = 0; j < 16 && j < acc_log[0].size(); j++)
      chk("fair_order", 0, W'(acc_log[0][j]), W'(j % 4));

    // burst lock: req0 3 beats while req1 keeps requesting
    clear_logs();
    start_pkt(0, 0, 3);
    refill[0][1] = 1'b1; refill_len[0][1] = 1; start_pkt(0, 1, 1);
    repeat (4) step();
    refill[0][1] = 1'b0;
    check_log("burst_lock", 0, 4, 0, 0, 0, 1);
    drain();

    // hold under backpressure
    clear_logs();
    start_pkt(0, 2, 1);
    dat[0][2] = 16'h00A5;
    ordy[0] = 1'b0;
    step();
    start_pkt(0, 1, 1);
    repeat (4) step();
    ordy[0] = 1'b1;
    repeat (2) step();
    check_log("hold", 0, 2, 2, 1, 0, 0);

    // bubble mid-burst
    clear_logs();
    start_pkt(0, 3, 2);
    step();
    vld[0][3] = 1'b0;
    start_pkt(0, 0, 1);
    repeat (2) step();
    vld[0][3] = 1'b1;
    repeat (2) step();
    check_log("bubble", 0, 3, 3, 3, 0, 0);

    // reset during beat 2 of a 4-beat packet
    clear_logs();
    start_pkt(0, 1, 4);
    step();
    rst_i = 1'b1;
    step();
    clear_all();
    rst_i = 1'b0;
    start_pkt(0, 0, 1);
    start_pkt(0, 1, 1);
    repeat (2) step();
    check_log("reset", 0, 3, 1, 0, 1, 0);

    // N=1 back-to-back 2-beat packets
    clear_logs();
    ordy[1] = 1'b1;
    refill[1][0] = 1'b1; refill_len[1][0] = 2;
    start_pkt(1, 0, 2);
    repeat (8) step();
    refill[1][0] = 1'b0;
    chk("n1_beats", 1, W'(acc_log[1].size()), W'(8));
    drain();

    // N=3 wrap-around from ptr=2
    clear_logs();
    ordy[2] = 1'b1;
    start_pkt(2, 2, 1);
    step();
    start_pkt(2, 0, 1);
    start_pkt(2, 2, 1);
    repeat (2) step();
    check_log("wrap", 2, 3, 2, 0, 2, 0);

    // randomized traffic on all instances
    rnd_mode = 1'b1;
    repeat (3000) step();
    rnd_mode = 1'b0;
    drain();

    for (int i = 0; i < NI; i++) chk("leftover", i, W'(exp_q[i].size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
